mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM register.
- Holds the word-organised data memory and performs sized, optionally signed loads and stores.
- Registers its results into the MEM/WB boundary, advancing under i_start && i_step.
- Provides a handshaked memory-dump port so the debug unit can read the whole data memory word by word while the pipeline is stalled or halted.

Parameters:
- DATA_WIDTH, 32, datapath and memory word width.
- ADDR_WIDTH, 5, word-address bits; memory depth is 2**ADDR_WIDTH words.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  pipeline run enable.
- i_step  in  1  step enable; the stage advances only when i_start && i_step ("adv").
- i_aluresult  in  DATA_WIDTH  byte address for memory ops; passthrough otherwise.
- i_regB  in  DATA_WIDTH  store data.
- i_rd_rt  in  5  destination register.
- i_mem  in  3  [2] read, [1] write, [0] reserved and ignored.
- i_wb  in  2  write-back controls, passed through.
- i_sizemem  in  2  00 byte, 01 half, 11 word, 10 treated as word.
- i_signedmem  in  1  1 = sign-extend loads, 0 = zero-extend loads.
- i_return_address  in  DATA_WIDTH  link address, passed through.
- i_return  in  1  link flag, passed through.
- i_halt  in  1  halt marker, passed through.
- i_dump_req  in  1  debug request to dump memory.
- i_dump_ready  in  1  debug consumer accepts the current dump word.
- o_readdata  out  DATA_WIDTH  registered load result.
- o_aluresult, o_rd_rt, o_wb, o_return_address, o_return, o_halt  out  same widths as inputs  registered passthroughs.
- o_misaligned  out  1  registered flag: the access in this slot was misaligned.
- o_dump_valid  out  1  o_dump_data / o_dump_addr are valid.
- o_dump_addr  out  ADDR_WIDTH  word index being dumped.
- o_dump_data  out  DATA_WIDTH  memory word at o_dump_addr.
- o_dump_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset: all outputs and registers go to 0 immediately (asynchronous); dump FSM goes to IDLE. Memory contents are not cleared.
- Addressing: word index = i_aluresult[ADDR_WIDTH+1:2]; lane = i_aluresult[1:0]; little-endian, so lane 0 is bits 7:0. Upper address bits are ignored, so addresses wrap modulo the memory size.
- Memory timing: asynchronous read, synchronous write.
- Stores happen on the adv clock edge when i_mem[1]=1:
  - Byte: writes lane [1:0] with i_regB[7:0].
  - Half: writes the lane pair selected by i_aluresult[1] with i_regB[15:0].
  - Word: writes the full word.
  - Other bytes in the word are preserved.
- Loads: the selected byte or half is sign- or zero-extended per i_signedmem and captured into o_readdata on the adv edge. If i_mem[2]=0, o_readdata captures 0.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - No write occurs; o_readdata captures 0; o_misaligned captures 1.
  - Otherwise o_misaligned captures 0.
- Read and write both set: treated as write only; o_readdata captures 0.
- Passthroughs: on each adv edge all o_* passthroughs capture their inputs, giving 1-cycle latency. When adv=0 every register holds and no memory write occurs.
- Dump FSM states:
  - IDLE -> DUMP when i_dump_req=1 and adv=0; addr counter cleared to 0.
  - DUMP: o_dump_valid=1; o_dump_data = mem[addr] (combinational). On i_dump_ready: if addr = DEPTH-1, go to DONE; else addr+1.
  - DONE: o_dump_done=1 for one cycle, then IDLE.
- During DUMP and DONE, adv is internally forced to 0, so no stores occur and MEM/WB holds.
- i_dump_req while busy is ignored. Data and address stay stable while valid=1 and ready=0.
- Reset asserted mid-dump: abort to IDLE with o_dump_valid=0.

Decomposition:
- Shared package: sizemem encodings (SZ_BYTE, SZ_HALF, SZ_WORD), i_mem bit indices (MEM_RD, MEM_WR), dump FSM state constants.
- One sub-module, data_memory: a DEPTH x DATA_WIDTH RAM with 4-bit byte-write-enable, asynchronous read port A (pipeline), and asynchronous read port B (dump).

Test Plan:
- Store word 0xDEADBEEF at addr 0x8, then load word at 0x8 signed -> o_readdata=0xDEADBEEF one adv edge later.
- Store byte 0x80 at addr 0x9, then load byte signed at 0x9 -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load word at 0x8 -> 0xDEAD80EF.
- Load half at addr 0xA, signed -> 0xFFFFDEAD; store half at addr 0x3 -> o_misaligned=1, o_readdata=0, memory unchanged.
- With i_step=0 and store requested at addr 0x4 -> mem[1] unchanged, all outputs hold previous values.
- i_dump_req with i_dump_ready held 1 -> 32 valid cycles with addr 0..31 matching preloaded data, then o_dump_done pulse; a ready=0 stall keeps the same word.
- Assert i_reset at dump addr 5 -> o_dump_valid=0 and all outputs 0 immediately; a new request restarts at addr 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM pipeline stage: access sizes, control bits, dump FSM states.
package mem_stage_pkg;

  localparam int unsigned LANE_W    = 2;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned MEM_CTL_W = 3;
  localparam int unsigned WB_W      = 2;
  localparam int unsigned SZ_W      = 2;

  localparam logic [SZ_W-1:0] SZ_BYTE = 2'b00;
  localparam logic [SZ_W-1:0] SZ_HALF = 2'b01;
  localparam logic [SZ_W-1:0] SZ_WORD = 2'b11;

  localparam int unsigned MEM_RD = 2;
  localparam int unsigned MEM_WR = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } dump_state_t;

  // Encoding 2'b10 is handled like a word access.
  function automatic logic is_misaligned(input logic [SZ_W-1:0] sz, input logic [LANE_W-1:0] lane);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      default: return (lane != '0);
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs, MEM/WB outputs and the debug memory-dump handshake of the MEM stage.
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);

  logic                  i_start;
  logic                  i_step;
  logic [DATA_WIDTH-1:0] i_aluresult;
  logic [DATA_WIDTH-1:0] i_regB;
  logic [REG_W-1:0]      i_rd_rt;
  logic [MEM_CTL_W-1:0]  i_mem;
  logic [WB_W-1:0]       i_wb;
  logic [SZ_W-1:0]       i_sizemem;
  logic                  i_signedmem;
  logic [DATA_WIDTH-1:0] i_return_address;
  logic                  i_return;
  logic                  i_halt;
  logic                  i_dump_req;
  logic                  i_dump_ready;

  logic [DATA_WIDTH-1:0] o_readdata;
  logic [DATA_WIDTH-1:0] o_aluresult;
  logic [REG_W-1:0]      o_rd_rt;
  logic [WB_W-1:0]       o_wb;
  logic [DATA_WIDTH-1:0] o_return_address;
  logic                  o_return;
  logic                  o_halt;
  logic                  o_misaligned;
  logic                  o_dump_valid;
  logic [ADDR_WIDTH-1:0] o_dump_addr;
  logic [DATA_WIDTH-1:0] o_dump_data;
  logic                  o_dump_done;

  modport slave (
    input  i_start, i_step, i_aluresult, i_regB, i_rd_rt, i_mem, i_wb, i_sizemem,
           i_signedmem, i_return_address, i_return, i_halt, i_dump_req, i_dump_ready,
    output o_readdata, o_aluresult, o_rd_rt, o_wb, o_return_address, o_return, o_halt,
           o_misaligned, o_dump_valid, o_dump_addr, o_dump_data, o_dump_done
  );

  modport master (
    output i_start, i_step, i_aluresult, i_regB, i_rd_rt, i_mem, i_wb, i_sizemem,
           i_signedmem, i_return_address, i_return, i_halt, i_dump_req, i_dump_ready,
    input  o_readdata, o_aluresult, o_rd_rt, o_wb, o_return_address, o_return, o_halt,
           o_misaligned, o_dump_valid, o_dump_addr, o_dump_data, o_dump_done
  );

endinterface

// File: rtl/mem_stage_data_memory.sv
// Word-organised data RAM: byte-enabled synchronous write, two asynchronous read ports.
module data_memory #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                    i_clock,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic [ADDR_WIDTH-1:0]   i_addr_a,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata_a,
  input  logic [ADDR_WIDTH-1:0]   i_addr_b,
  output logic [DATA_WIDTH-1:0]   o_rdata_b
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clock) begin
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (i_be[b]) begin
        r_mem[i_addr_a][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_rdata_a = r_mem[i_addr_a];
  assign o_rdata_b = r_mem[i_addr_b];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: sized/signed loads and stores, MEM/WB register, debug memory dump FSM.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic      i_clock,
  input  logic      i_reset,
  mem_stage_if.slave bus
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

  dump_state_t             r_state;
  logic [ADDR_WIDTH-1:0]   r_dump_addr;
  logic                    r_dump_valid;
  logic                    r_dump_done;

  logic [DATA_WIDTH-1:0]   r_readdata;
  logic [DATA_WIDTH-1:0]   r_aluresult;
  logic [REG_W-1:0]        r_rd_rt;
  logic [WB_W-1:0]         r_wb;
  logic [DATA_WIDTH-1:0]   r_return_address;
  logic                    r_return;
  logic                    r_halt;
  logic                    r_misaligned;

  logic                    w_adv;
  logic [ADDR_WIDTH-1:0]   w_word_idx;
  logic [LANE_W-1:0]       w_lane;
  logic                    w_rd;
  logic                    w_wr;
  logic                    w_mis;
  logic [NUM_BYTES-1:0]    w_be;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [DATA_WIDTH-1:0]   w_rdata_a;
  logic [DATA_WIDTH-1:0]   w_rdata_b;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [DATA_WIDTH-1:0]   w_load;
  logic [DATA_WIDTH-1:0]   w_readdata_next;
  logic                    w_unused;

  // The pipeline is frozen for the whole time the dump FSM is busy.
  assign w_adv      = bus.i_start & bus.i_step & (r_state == ST_IDLE);
  assign w_word_idx = bus.i_aluresult[ADDR_WIDTH+1:2];
  assign w_lane     = bus.i_aluresult[1:0];
  assign w_rd       = bus.i_mem[MEM_RD];
  assign w_wr       = bus.i_mem[MEM_WR];
  assign w_mis      = (w_rd | w_wr) & is_misaligned(bus.i_sizemem, w_lane);
  assign w_unused   = ^{bus.i_mem[0], bus.i_aluresult[DATA_WIDTH-1:ADDR_WIDTH+2]};

  always_comb begin
    w_be    = '0;
    w_wdata = bus.i_regB;
    case (bus.i_sizemem)
      SZ_BYTE: w_wdata = {NUM_BYTES{bus.i_regB[7:0]}};
      SZ_HALF: w_wdata = {(NUM_BYTES/2){bus.i_regB[15:0]}};
      default: w_wdata = bus.i_regB;
    endcase
    if (w_adv && w_wr && !w_mis) begin
      case (bus.i_sizemem)
        SZ_BYTE: w_be = NUM_BYTES'(1) << w_lane;
        SZ_HALF: w_be = NUM_BYTES'(2'b11) << {w_lane[1], 1'b0};
        default: w_be = '1;
      endcase
    end
  end

  data_memory #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_data_memory (
    .i_clock  (i_clock),
    .i_be     (w_be),
    .i_addr_a (w_word_idx),
    .i_wdata  (w_wdata),
    .o_rdata_a(w_rdata_a),
    .i_addr_b (r_dump_addr),
    .o_rdata_b(w_rdata_b)
  );

  assign w_byte = w_rdata_a[{w_lane, 3'b000} +: 8];
  assign w_half = w_rdata_a[{w_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_load = w_rdata_a;
    case (bus.i_sizemem)
      SZ_BYTE: w_load = bus.i_signedmem ? {{(DATA_WIDTH-8){w_byte[7]}}, w_byte}
                                        : {{(DATA_WIDTH-8){1'b0}}, w_byte};
      SZ_HALF: w_load = bus.i_signedmem ? {{(DATA_WIDTH-16){w_half[15]}}, w_half}
                                        : {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: w_load = w_rdata_a;
    endcase
  end

  // A simultaneous read+write is a store only; misaligned accesses return zero.
  assign w_readdata_next = (w_rd && !w_wr && !w_mis) ? w_load : '0;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_readdata       <= '0;
      r_aluresult      <= '0;
      r_rd_rt          <= '0;
      r_wb             <= '0;
      r_return_address <= '0;
      r_return         <= 1'b0;
      r_halt           <= 1'b0;
      r_misaligned     <= 1'b0;
    end else if (w_adv) begin
      r_readdata       <= w_readdata_next;
      r_aluresult      <= bus.i_aluresult;
      r_rd_rt          <= bus.i_rd_rt;
      r_wb             <= bus.i_wb;
      r_return_address <= bus.i_return_address;
      r_return         <= bus.i_return;
      r_halt           <= bus.i_halt;
      r_misaligned     <= w_mis;
    end
  end

  // Dump walks every word once; a new request is accepted only from IDLE while the pipeline is not advancing.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_dump_addr  <= '0;
      r_dump_valid <= 1'b0;
      r_dump_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_dump_req && !(bus.i_start && bus.i_step)) begin
            r_state      <= ST_DUMP;
            r_dump_addr  <= '0;
            r_dump_valid <= 1'b1;
          end
        end
        ST_DUMP: begin
          if (bus.i_dump_ready) begin
            if (r_dump_addr == ADDR_WIDTH'(DEPTH - 1)) begin
              r_state      <= ST_DONE;
              r_dump_valid <= 1'b0;
              r_dump_done  <= 1'b1;
            end else begin
              r_dump_addr <= r_dump_addr + ADDR_WIDTH'(1);
            end
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_dump_done <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_dump_valid <= 1'b0;
          r_dump_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_readdata       = r_readdata;
  assign bus.o_aluresult      = r_aluresult;
  assign bus.o_rd_rt          = r_rd_rt;
  assign bus.o_wb             = r_wb;
  assign bus.o_return_address = r_return_address;
  assign bus.o_return         = r_return;
  assign bus.o_halt           = r_halt;
  assign bus.o_misaligned     = r_misaligned;
  assign bus.o_dump_valid     = r_dump_valid;
  assign bus.o_dump_addr      = r_dump_addr;
  assign bus.o_dump_data      = r_dump_valid ? w_rdata_b : '0;
  assign bus.o_dump_done      = r_dump_done;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte-addressed reference model plus directed literal checks.
module tb_mem_stage;

  logic clk;
  logic rst;

  mem_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: little-endian byte array, expected MEM/WB values, dump position (-1 idle, 32 done).
  logic [7:0]  mem_b [128];
  logic [31:0] e_rd, e_alu, e_ra;
  logic [4:0]  e_rdrt;
  logic [1:0]  e_wb;
  logic        e_ret, e_halt, e_mis;
  int          dpos = -1;
  logic [31:0] pre [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    return {mem_b[a+3], mem_b[a+2], mem_b[a+1], mem_b[a]};
  endfunction

  task automatic model_access();
    int a, sz;
    logic rd, wr;
    logic [31:0] val;
    a  = int'(bus.i_aluresult[6:0]);
    sz = (bus.i_sizemem == 2'b00) ? 1 : (bus.i_sizemem == 2'b01) ? 2 : 4;
    rd = bus.i_mem[2];
    wr = bus.i_mem[1];
    e_mis = (rd || wr) && (a % sz != 0);
    val = 0;
    if (rd && !wr && !e_mis) begin
      for (int k = 0; k < sz; k++) val = val | (32'(mem_b[a+k]) << (8*k));
      if (bus.i_signedmem && sz < 4 && val[8*sz-1]) val = val | (32'hFFFF_FFFF << (8*sz));
    end
    e_rd = val;
    if (wr && !e_mis)
      for (int k = 0; k < sz; k++) mem_b[a+k] = 8'(bus.i_regB >> (8*k));
    e_alu  = bus.i_aluresult;
    e_rdrt = bus.i_rd_rt;
    e_wb   = bus.i_wb;
    e_ra   = bus.i_return_address;
    e_ret  = bus.i_return;
    e_halt = bus.i_halt;
  endtask

  task automatic compare_all();
    logic v;
    v = (dpos >= 0 && dpos < 32);
    chk("readdata", bus.o_readdata, e_rd);
    chk("aluresult", bus.o_aluresult, e_alu);
    chk("rd_rt", 32'(bus.o_rd_rt), 32'(e_rdrt));
    chk("wb", 32'(bus.o_wb), 32'(e_wb));
    chk("return_address", bus.o_return_address, e_ra);
    chk("return", 32'(bus.o_return), 32'(e_ret));
    chk("halt", 32'(bus.o_halt), 32'(e_halt));
    chk("misaligned", 32'(bus.o_misaligned), 32'(e_mis));
    chk("dump_valid", 32'(bus.o_dump_valid), 32'(v));
    chk("dump_done", 32'(bus.o_dump_done), 32'(dpos == 32));
    if (v) begin
      chk("dump_addr", 32'(bus.o_dump_addr), 32'(dpos));
      chk("dump_data", bus.o_dump_data, word_at(dpos * 4));
    end
  endtask

  // Model update and comparison on every clock edge and on reset assertion.
  always @(posedge clk or posedge rst) begin
    logic adv;
    if (rst) begin
      e_rd = 0; e_alu = 0; e_ra = 0; e_rdrt = 0; e_wb = 0;
      e_ret = 0; e_halt = 0; e_mis = 0; dpos = -1;
    end else begin
      adv = bus.i_start && bus.i_step && (dpos < 0);
      if (dpos < 0) begin
        if (bus.i_dump_req && !(bus.i_start && bus.i_step)) dpos = 0;
      end else if (dpos == 32) begin
        dpos = -1;
      end else if (bus.i_dump_ready) begin
        dpos = dpos + 1;
      end
      if (adv) model_access();
    end
    #1;
    compare_all();
  end

  task automatic op(input logic [2:0] m, input logic [1:0] sz, input logic sg,
                    input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.i_start = 1; bus.i_step = 1; bus.i_dump_req = 0;
    bus.i_mem = m; bus.i_sizemem = sz; bus.i_signedmem = sg;
    bus.i_aluresult = addr; bus.i_regB = data;
    bus.i_rd_rt = 5'($urandom); bus.i_wb = 2'($urandom);
    bus.i_return_address = $urandom; bus.i_return = 1'($urandom); bus.i_halt = 1'($urandom);
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (dpos != -1 && n < 200) begin
      @(negedge clk);
      bus.i_dump_ready = 1; bus.i_dump_req = 0;
      n++;
    end
    if (dpos != -1) chk("idle_wait_timeout", 32'(dpos), 32'hFFFF_FFFF);
  endtask

  initial begin
    int nv, nd, n;
    rst = 1;
    bus.i_start = 0; bus.i_step = 0; bus.i_aluresult = 0; bus.i_regB = 0;
    bus.i_rd_rt = 0; bus.i_mem = 0; bus.i_wb = 0; bus.i_sizemem = 0;
    bus.i_signedmem = 0; bus.i_return_address = 0; bus.i_return = 0; bus.i_halt = 0;
    bus.i_dump_req = 0; bus.i_dump_ready = 0;
    repeat (3) @(negedge clk);
    chk("reset_readdata", bus.o_readdata, 32'h0);
    chk("reset_dump_valid", 32'(bus.o_dump_valid), 32'h0);
    rst = 0;

    for (int i = 0; i < 32; i++) begin
      pre[i] = $urandom;
      op(3'b010, 2'b11, 0, 32'(i * 4), pre[i]);
    end

    op(3'b010, 2'b11, 0, 32'h8, 32'hDEADBEEF);
    op(3'b100, 2'b11, 1, 32'h8, 32'h0);
    chk("lit_load_word", bus.o_readdata, 32'hDEADBEEF);
    op(3'b010, 2'b00, 0, 32'h9, 32'h0000_0080);
    op(3'b100, 2'b00, 1, 32'h9, 32'h0);
    chk("lit_load_byte_s", bus.o_readdata, 32'hFFFF_FF80);
    op(3'b100, 2'b00, 0, 32'h9, 32'h0);
    chk("lit_load_byte_u", bus.o_readdata, 32'h0000_0080);
    op(3'b100, 2'b11, 0, 32'h8, 32'h0);
    chk("lit_load_word2", bus.o_readdata, 32'hDEAD80EF);
    op(3'b100, 2'b01, 1, 32'hA, 32'h0);
    chk("lit_load_half_s", bus.o_readdata, 32'hFFFF_DEAD);
    op(3'b010, 2'b01, 0, 32'h3, 32'h0000_BEEF);
    chk("lit_mis_flag", 32'(bus.o_misaligned), 32'h1);
    chk("lit_mis_data", bus.o_readdata, 32'h0);
    op(3'b100, 2'b11, 0, 32'h0, 32'h0);
    chk("lit_mis_nowrite", bus.o_readdata, pre[0]);
    op(3'b110, 2'b11, 0, 32'h10, 32'h1234_5678);
    chk("lit_rdwr_data", bus.o_readdata, 32'h0);

    // Stalled store must not land and outputs must hold.
    op(3'b100, 2'b11, 0, 32'h0, 32'h0);
    @(negedge clk);
    bus.i_step = 0; bus.i_mem = 3'b010; bus.i_aluresult = 32'h4; bus.i_regB = 32'h0BAD_F00D;
    @(posedge clk); #2;
    chk("lit_hold_readdata", bus.o_readdata, pre[0]);
    op(3'b100, 2'b11, 0, 32'h4, 32'h0);
    chk("lit_hold_nowrite", bus.o_readdata, pre[1]);

    // Full dump with ready held high.
    @(negedge clk);
    bus.i_start = 0; bus.i_dump_req = 1; bus.i_dump_ready = 1;
    nv = 0; nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus.i_dump_req = 0;
      if (bus.o_dump_valid) nv++;
      if (bus.o_dump_done) nd++;
    end
    chk("lit_dump_valid_cycles", 32'(nv), 32'd32);
    chk("lit_dump_done_pulses", 32'(nd), 32'd1);

    // Stall on word 3.
    bus.i_dump_req = 1;
    n = 0;
    while (!(bus.o_dump_valid && bus.o_dump_addr == 5'd3) && n < 50) begin
      @(negedge clk);
      bus.i_dump_req = 0;
      n++;
    end
    bus.i_dump_ready = 0;
    repeat (3) begin
      @(negedge clk);
      chk("lit_stall_addr", 32'(bus.o_dump_addr), 32'd3);
      chk("lit_stall_data", bus.o_dump_data, word_at(12));
    end
    wait_idle();

    // Reset in the middle of a dump, then restart.
    @(negedge clk);
    bus.i_dump_req = 1; bus.i_dump_ready = 1;
    n = 0;
    while (!(bus.o_dump_valid && bus.o_dump_addr == 5'd5) && n < 50) begin
      @(negedge clk);
      bus.i_dump_req = 0;
      n++;
    end
    chk("lit_reached_addr5", 32'(bus.o_dump_addr), 32'd5);
    #2 rst = 1;
    #1;
    chk("lit_rst_dump_valid", 32'(bus.o_dump_valid), 32'h0);
    chk("lit_rst_dump_data", bus.o_dump_data, 32'h0);
    chk("lit_rst_readdata", bus.o_readdata, 32'h0);
    chk("lit_rst_aluresult", bus.o_aluresult, 32'h0);
    @(negedge clk);
    rst = 0;
    bus.i_dump_req = 1;
    @(posedge clk); #2;
    chk("lit_restart_valid", 32'(bus.o_dump_valid), 32'h1);
    chk("lit_restart_addr", 32'(bus.o_dump_addr), 32'h0);
    wait_idle();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bus.i_start = ($urandom % 8) != 0;
      bus.i_step = ($urandom % 4) != 0;
      bus.i_aluresult = $urandom;
      bus.i_regB = $urandom;
      bus.i_mem = 3'($urandom);
      bus.i_sizemem = 2'($urandom);
      bus.i_signedmem = 1'($urandom);
      bus.i_rd_rt = 5'($urandom);
      bus.i_wb = 2'($urandom);
      bus.i_return_address = $urandom;
      bus.i_return = 1'($urandom);
      bus.i_halt = 1'($urandom);
      bus.i_dump_req = ($urandom % 60) == 0;
      bus.i_dump_ready = ($urandom % 4) != 0;
    end
    wait_idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
